// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencer, one-deep in-flight tracking and a 2-entry {instr, pc} queue to decode.
// Optional build macro IF_PERF_CNT_EN adds the fetch_count output (instructions handed to decode).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int DEPTH = 2;

    logic [31:0] pc_reg;
    logic [31:0] req_addr_reg;
    logic        inflight_reg;
    logic [31:0] instr_reg [DEPTH];
    logic [31:0] epc_reg   [DEPTH];
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  count_reg;

    logic        pop_raw;
    logic        pop;
    logic        push;
    logic [2:0]  occupancy;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign if_valid  = reset & (count_reg != 2'd0);
    assign if_instr  = instr_reg[rd_ptr_reg];
    assign if_pc     = epc_reg[rd_ptr_reg];
    assign imem_addr = pc_reg;

    // Slots already claimed (buffered + in flight) after this cycle's pop; a new
    // request is only issued when its response is guaranteed a FIFO slot.
    assign pop_raw   = if_valid & id_ready;
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop_raw};
    assign imem_req  = reset & ~redirect & (occupancy < 3'd2);

    assign pop  = pop_raw & ~redirect;
    assign push = reset & inflight_reg & ~redirect;

    // Queue storage: written only, never reset; pointers/count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_reg[wr_ptr_reg] <= imem_rdata;
            epc_reg[wr_ptr_reg]   <= req_addr_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else if (redirect) begin
            // Flush: buffered entries and the outstanding response are dropped.
            pc_reg       <= {redirect_pc[31:2], 2'b00};
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            inflight_reg <= imem_req;
            if (imem_req) begin
                pc_reg       <= pc_reg + 32'd4;
                req_addr_reg <= pc_reg;
            end
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_count_reg <= 32'd0;
        end else if (pop) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

    assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random traffic,
// checked against a request/response scoreboard of the fetch stream.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] w_fetch_count;
`endif

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    // Second instance only exercises the PC wrap from a high reset vector.
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_rdata  (w_imem_rdata),
        .if_valid    (w_if_valid),
        .if_instr    (w_if_instr),
        .if_pc       (w_if_pc),
        .id_ready    (1'b1),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count (w_fetch_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory answers one cycle after a request; garbage otherwise so stale data is visible.
    always @(posedge clock) begin
        imem_rdata   <= imem_req ? mem_word(imem_addr) : $urandom();
        w_imem_rdata <= w_imem_req ? mem_word(w_imem_addr) : $urandom();
    end

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } req_t;

    req_t        pending[$];
    logic [31:0] next_pc;
    int          cyc;
    int          pop_total;
    int          n_compared;
    int          n_mismatched;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Compare the DUT against the scoreboard, then advance the scoreboard across the coming edge.
    task automatic evaluate();
        logic exp_valid;
        logic exp_pop;
        logic exp_req;
        int   claimed;
        exp_valid = reset && pending.size() > 0 && (pending[0].cyc + 2 <= cyc);
        check_value("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
        if (exp_valid && if_valid) begin
            check_value("if_pc", if_pc, pending[0].addr);
            check_value("if_instr", if_instr, mem_word(pending[0].addr));
        end
        exp_pop = exp_valid && id_ready;
        claimed = pending.size() - (exp_pop ? 1 : 0);
        exp_req = reset && !redirect && (claimed < 2);
        check_value("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req && imem_req) begin
            check_value("imem_addr", imem_addr, next_pc);
        end
`ifdef IF_PERF_CNT_EN
        check_value("fetch_count", fetch_count, pop_total);
`endif
        if (!reset) begin
            pending.delete();
            next_pc   = 32'h0000_0000;
            pop_total = 0;
        end else if (redirect) begin
            pending.delete();
            next_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_pop) begin
                $display("pop   pc=%h instr=%h cycle=%0d", pending[0].addr, mem_word(pending[0].addr), cyc);
                void'(pending.pop_front());
                pop_total++;
            end
            if (exp_req) begin
                pending.push_back('{addr: next_pc, cyc: cyc});
                next_pc = next_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(posedge clock);
        #1;
        reset       = rst_n;
        redirect    = redir;
        redirect_pc = rpc;
        id_ready    = rdy;
        cyc++;
        @(negedge clock);
        evaluate();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        pop_total    = 0;
        next_pc      = 32'd0;
        reset        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        id_ready     = 1'b0;

        // Reset state
        do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_value("rst_req", {31'd0, imem_req}, 32'd0);
        check_value("rst_valid", {31'd0, if_valid}, 32'd0);

        // Streaming from reset, decode always ready; wrap instance runs alongside
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("s_addr0", imem_addr, 32'h0000_0000);
        check_value("w_addr0", w_imem_addr, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("s_addr1", imem_addr, 32'h0000_0004);
        check_value("w_addr1", w_imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("s_addr2", imem_addr, 32'h0000_0008);
        check_value("w_addr2", w_imem_addr, 32'h0000_0000);
        check_value("s_valid", {31'd0, if_valid}, 32'd1);
        check_value("s_pc0", if_pc, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("s_pc1", if_pc, 32'h0000_0004);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("s_pc2", if_pc, 32'h0000_0008);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Stall with two fetched, then resume
        do_reset();
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            check_value("stall_req", {31'd0, imem_req}, 32'd0);
            check_value("stall_pc", if_pc, 32'h0000_0000);
            check_value("stall_instr", if_instr, mem_word(32'h0000_0000));
        end
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("resume_pc0", if_pc, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("resume_pc1", if_pc, 32'h0000_0004);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("resume_pc2", if_pc, 32'h0000_0008);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect with one buffered entry and one response in flight
        do_reset();
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
        check_value("redir_req", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("redir_valid", {31'd0, if_valid}, 32'd0);
        check_value("redir_addr", imem_addr, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Wrap on the main instance via redirect
        step(1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Reset mid-stream with a full FIFO
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
        check_value("full_valid", {31'd0, if_valid}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check_value("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check_value("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check_value("post_rst_addr", imem_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Five pops then a redirect; the scoreboard tracks the pop count throughout
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_4000, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r_rst;
            logic        r_redir;
            logic [31:0] r_pc;
            logic        r_rdy;
            r_rst   = ($urandom_range(0, 49) != 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            r_rdy   = ($urandom_range(0, 9) < 7);
            step(r_rst, r_redir, r_pc, r_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
